// File: rtl/keypad_scanner_pkg.sv
// keypad_scanner_pkg
// Shared definitions for the keypad scanner and its downstream consumer:
// scanner FSM state encoding, key type codes and the symbol key codes.
// Also provides a helper that classifies a key code as NUMBER or SYMBOL.
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  localparam logic NUMBER = 1'b0;
  localparam logic SYMBOL = 1'b1;

  localparam logic [3:0] A_BUT       = 4'hA;
  localparam logic [3:0] B_BUT       = 4'hB;
  localparam logic [3:0] C_BUT       = 4'hC;
  localparam logic [3:0] D_BUT       = 4'hD;
  localparam logic [3:0] NUMERAL_BUT = 4'hE;
  localparam logic [3:0] FN_BUT      = 4'hF;

  // Digits 0-9 are numbers; every code from A upward (including the
  // NUMERAL and FN function keys) is treated as a symbol.
  function automatic logic keyTypeOf(input logic [3:0] code);
    return (code >= A_BUT) ? SYMBOL : NUMBER;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if
// Bundles the keypad scanner's environment-facing and consumer-facing
// signals.
//   master : the scanner itself (samples enable/row_result, drives the rest)
//   slave  : the environment / downstream FSM side
// Signals:
//   enable        scan enable, low forces idle
//   row_result    raw active-low row lines from the keypad
//   col_selector  encoded column index to the external column decoder
//   valid_out     high while a debounced key is held
//   keytype       0 = NUMBER, 1 = SYMBOL
//   key           key code, stable while valid_out is high
//   number_signal one-cycle strobe on accepting a number key
//   symbol_signal one-cycle strobe on accepting a symbol key
interface keypad_scanner_if;
  logic       enable;
  logic [3:0] row_result;
  logic [1:0] col_selector;
  logic       valid_out;
  logic       keytype;
  logic [3:0] key;
  logic       number_signal;
  logic       symbol_signal;

  modport master (
    input  enable, row_result,
    output col_selector, valid_out, keytype, key, number_signal, symbol_signal
  );

  modport slave (
    output enable, row_result,
    input  col_selector, valid_out, keytype, key, number_signal, symbol_signal
  );
endinterface

// File: rtl/keypad_scanner_decode.sv
// keypad_decode
// Purely combinational map from a {row, column} position on the 4x4 matrix
// to the key code and its type.
// Ports:
//   i_row     row index 0..3
//   i_col     column index 0..3
//   o_key     key code
//   o_keytype NUMBER/SYMBOL classification of o_key
module keypad_decode
  import keypad_scanner_pkg::*;
(
  input  logic [1:0] i_row,
  input  logic [1:0] i_col,
  output logic [3:0] o_key,
  output logic       o_keytype
);

  // Physical layout: the bottom row carries FN, 0, NUMERAL and D.
  always_comb begin
    o_key = 4'h0;
    case ({i_row, i_col})
      4'h0: o_key = 4'h1;
      4'h1: o_key = 4'h2;
      4'h2: o_key = 4'h3;
      4'h3: o_key = A_BUT;
      4'h4: o_key = 4'h4;
      4'h5: o_key = 4'h5;
      4'h6: o_key = 4'h6;
      4'h7: o_key = B_BUT;
      4'h8: o_key = 4'h7;
      4'h9: o_key = 4'h8;
      4'hA: o_key = 4'h9;
      4'hB: o_key = C_BUT;
      4'hC: o_key = FN_BUT;
      4'hD: o_key = 4'h0;
      4'hE: o_key = NUMERAL_BUT;
      4'hF: o_key = D_BUT;
      default: o_key = 4'h0;
    endcase
    o_keytype = keyTypeOf(o_key);
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one column at a time, debounces
// press and release, and presents a held key code with a level valid plus
// one-cycle NUMBER/SYMBOL strobes on acceptance.
// Ports:
//   clock  system clock
//   reset  synchronous active-high reset
//   bus    keypad_scanner_if.master (enable, row_result in; column select,
//          valid, key, keytype and strobes out)
// Parameters:
//   SCAN_DIV       cycles each column is selected while scanning (>=4)
//   DEBOUNCE_CNT   stable cycles needed to accept a press or release (>=2)
//   REPEAT_CYCLES  held cycles between auto-repeat drops
// Configuration macro:
//   KEYPAD_AUTOREPEAT_EN  when defined, a held key periodically drops
//                         valid for one cycle and re-strobes.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV      = 1000,
  parameter int DEBOUNCE_CNT  = 20000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input logic               clock,
  input logic               reset,
  keypad_scanner_if.master  bus
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int DB_W   = $clog2(DEBOUNCE_CNT);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CNT - 1);

  generate
    if (SCAN_DIV < 4 || DEBOUNCE_CNT < 2 || REPEAT_CYCLES < 1) begin : g_paramCheck
      $error("keypad_scanner: SCAN_DIV>=4, DEBOUNCE_CNT>=2, REPEAT_CYCLES>=1 required");
    end
  endgenerate

  state_t            r_state;
  logic [3:0]        r_rowMeta;
  logic [3:0]        r_rowSync;
  logic [SCAN_W-1:0] r_scanCnt;
  logic [DB_W-1:0]   r_dbCnt;
  logic [1:0]        r_col;
  logic [1:0]        r_row;
  logic              r_valid;
  logic [3:0]        r_key;
  logic              r_keytype;
  logic              r_numStb;
  logic              r_symStb;

  logic [3:0]        w_active;
  logic              w_anyActive;
  logic [1:0]        w_lowRow;
  logic [3:0]        w_key;
  logic              w_keytype;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0]  r_repCnt;
  logic              r_repDrop;
`endif

  // Rows are asynchronous to clock; idle (released) level is all ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rowMeta <= 4'hF;
      r_rowSync <= 4'hF;
    end else begin
      r_rowMeta <= bus.row_result;
      r_rowSync <= r_rowMeta;
    end
  end

  assign w_active    = ~r_rowSync;
  assign w_anyActive = |w_active;

  // Lowest-numbered active row wins when several are pressed together.
  always_comb begin
    w_lowRow = 2'd0;
    if (w_active[0])      w_lowRow = 2'd0;
    else if (w_active[1]) w_lowRow = 2'd1;
    else if (w_active[2]) w_lowRow = 2'd2;
    else if (w_active[3]) w_lowRow = 2'd3;
  end

  keypad_decode u_decode (
    .i_row     (r_row),
    .i_col     (r_col),
    .o_key     (w_key),
    .o_keytype (w_keytype)
  );

  // Main scan/debounce FSM. While a key is latched the column stays frozen,
  // so presses in other columns are simply invisible until scanning resumes.
  // Leaving PRESS_DB or REL_DB back to SCAN always steps to the next column
  // so a stuck or bouncing key cannot monopolise the scanner.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= SCAN;
      r_scanCnt <= '0;
      r_dbCnt   <= '0;
      r_col     <= 2'd0;
      r_row     <= 2'd0;
      r_valid   <= 1'b0;
      r_key     <= 4'h0;
      r_keytype <= NUMBER;
      r_numStb  <= 1'b0;
      r_symStb  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      r_repCnt  <= '0;
      r_repDrop <= 1'b0;
`endif
    end else if (!bus.enable) begin
      // Column, key and keytype hold; everything else goes idle.
      r_state   <= SCAN;
      r_scanCnt <= '0;
      r_dbCnt   <= '0;
      r_valid   <= 1'b0;
      r_numStb  <= 1'b0;
      r_symStb  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      r_repCnt  <= '0;
      r_repDrop <= 1'b0;
`endif
    end else begin
      r_numStb <= 1'b0;
      r_symStb <= 1'b0;
      case (r_state)
        SCAN: begin
          if (r_scanCnt == SCAN_LAST) begin
            r_scanCnt <= '0;
            if (w_anyActive) begin
              r_row   <= w_lowRow;
              r_dbCnt <= '0;
              r_state <= PRESS_DB;
            end else begin
              r_col <= r_col + 2'd1;
            end
          end else begin
            r_scanCnt <= r_scanCnt + SCAN_W'(1);
          end
        end

        PRESS_DB: begin
          if (w_anyActive && (w_lowRow == r_row)) begin
            if (r_dbCnt == DB_LAST) begin
              r_dbCnt   <= '0;
              r_state   <= HELD;
              r_valid   <= 1'b1;
              r_key     <= w_key;
              r_keytype <= w_keytype;
              r_numStb  <= (w_keytype == NUMBER);
              r_symStb  <= (w_keytype == SYMBOL);
`ifdef KEYPAD_AUTOREPEAT_EN
              r_repCnt  <= '0;
`endif
            end else begin
              r_dbCnt <= r_dbCnt + DB_W'(1);
            end
          end else begin
            r_dbCnt   <= '0;
            r_scanCnt <= '0;
            r_col     <= r_col + 2'd1;
            r_state   <= SCAN;
          end
        end

        HELD: begin
`ifdef KEYPAD_AUTOREPEAT_EN
          // A repeat drop lasts exactly one cycle; the re-assert comes
          // with a fresh strobe so the consumer sees a new keystroke.
          if (r_repDrop) begin
            r_repDrop <= 1'b0;
            r_repCnt  <= '0;
            r_valid   <= 1'b1;
            r_numStb  <= (r_keytype == NUMBER);
            r_symStb  <= (r_keytype == SYMBOL);
          end else if (!w_anyActive) begin
            r_repCnt <= '0;
            r_dbCnt  <= '0;
            r_state  <= REL_DB;
          end else if (r_repCnt == REP_LAST) begin
            r_repCnt  <= '0;
            r_repDrop <= 1'b1;
            r_valid   <= 1'b0;
          end else begin
            r_repCnt <= r_repCnt + REP_W'(1);
          end
`else
          if (!w_anyActive) begin
            r_dbCnt <= '0;
            r_state <= REL_DB;
          end
`endif
        end

        REL_DB: begin
          if (w_anyActive) begin
            r_dbCnt <= '0;
            r_state <= HELD;
          end else if (r_dbCnt == DB_LAST) begin
            r_dbCnt   <= '0;
            r_scanCnt <= '0;
            r_valid   <= 1'b0;
            r_col     <= r_col + 2'd1;
            r_state   <= SCAN;
          end else begin
            r_dbCnt <= r_dbCnt + DB_W'(1);
          end
        end

        default: r_state <= SCAN;
      endcase
    end
  end

  assign bus.col_selector  = r_col;
  assign bus.valid_out     = r_valid;
  assign bus.key           = r_key;
  assign bus.keytype       = r_keytype;
  assign bus.number_signal = r_numStb;
  assign bus.symbol_signal = r_symStb;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream stage of the calculator control FSM: scans a 4x4 matrix keypad, debounces, and presents one decoded key code with a level-valid flag plus one-cycle type strobes.
- Drives column select to the external column decoder, samples the four raw row lines, and holds the key stable for the whole press.

Parameters:
- SCAN_DIV, 1000, clock cycles each column stays selected while scanning (>=4).
- DEBOUNCE_CNT, 20000, consecutive stable cycles required to accept a press or a release (>=2).
- REPEAT_CYCLES, 5000000, hold time between auto-repeat drops (used only with the optional feature).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  scan enable. Low forces the idle state.
- row_result  in  4  raw row lines, active-low, asynchronous to clock.
- col_selector  out  2  encoded active column index, 0..3.
- valid_out  out  1  high while a debounced key is held.
- keytype  out  1  0 = NUMBER (keys 0-9), 1 = SYMBOL (A-F).
- key  out  4  key code, stable while valid_out=1.
- number_signal  out  1  one-cycle strobe on accepting a NUMBER key.
- symbol_signal  out  1  one-cycle strobe on accepting a SYMBOL key.

Behaviour:
- Reset values: col_selector=0, valid_out=0, keytype=0, key=0, both strobes 0, state SCAN, all counters 0.
- Input sync: row_result passes through a 2-flop synchronizer. "Active" means a synchronized bit equals 0.
- Key map, row r / column c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: F 0 E D
  - F is the FN key. E is the NUMERAL key.
- State SCAN:
  - col_selector increments every SCAN_DIV cycles and wraps 3->0.
  - In the last cycle of a column's dwell, if any synchronized row is active: latch the row (lowest active index wins on multiple rows), freeze the column, go to PRESS_DB.
- State PRESS_DB:
  - The counter increments while the same single row stays the lowest active row.
  - Any change (release, or a different lowest row): clear the counter, return to SCAN, and continue from the next column.
  - Counter reaches DEBOUNCE_CNT: go to HELD. In the same cycle assert valid_out, load key and keytype, and pulse the matching strobe for exactly 1 cycle.
- State HELD:
  - Column stays frozen. valid_out=1. key and keytype do not change.
  - The first cycle with no active row goes to REL_DB.
- State REL_DB:
  - The counter increments while no row is active. Any active row returns to HELD with the counter cleared.
  - Counter reaches DEBOUNCE_CNT: clear valid_out, go to SCAN, resume at the next column.
  - key and keytype keep their last value.
- Latency: pin press to valid_out rising is 2 sync cycles + up to 4*SCAN_DIV scan cycles + DEBOUNCE_CNT cycles.
- Second key pressed in another column while HELD: ignored. Only the frozen column is observed.
- enable low:
  - Next cycle: state SCAN, counters 0, valid_out 0, strobes 0, col_selector holds.
  - When enable returns high, scanning resumes.
- reset during any state: returns to the reset values on the next edge. No strobe is emitted.
- Strobes are mutually exclusive and are never asserted outside the HELD-entry cycle.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined:
  - In HELD, a repeat counter runs.
  - After REPEAT_CYCLES, valid_out drops for exactly 1 cycle, then re-asserts together with the matching strobe. The counter restarts.
  - The downstream FSM's edge detection sees a new key.
- Not defined:
  - No repeat counter is synthesized.
  - valid_out stays high for the whole press.

Decomposition:
- Shared package/header:
  - keytype constants NUMBER=0, SYMBOL=1.
  - Key code constants A_BUT..D_BUT=4'hA..4'hD, NUMERAL_BUT=4'hE, FN_BUT=4'hF.
  - State encodings SCAN/PRESS_DB/HELD/REL_DB.
  - The FSM consumer reuses the key constants.
- One sub-module: keypad_decode, a combinational {row,col} -> {key,keytype} map, so the table can be verified on its own.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_CNT=8, REPEAT_CYCLES=64.
1. Reset, then hold row_result=4'hF for 40 cycles -> col_selector cycles 0,1,2,3,0 with 4-cycle dwell; valid_out=0; no strobes.
2. Hold row1 low while col_selector=2 -> after 8 stable cycles: valid_out=1, key=6, keytype=0, number_signal high 1 cycle. Release -> valid_out=0 8 cycles later.
3. Row3 low on col 0, then bounce high for 3 cycles inside PRESS_DB -> no valid_out. Then stable low -> key=4'hF, keytype=1, symbol_signal pulse.
4. Rows 0 and 2 both low on col 3 -> key=4'hA (row 0 wins). A press on col 1 during HELD -> key unchanged.
5. enable deasserted during HELD -> valid_out=0 next cycle. Assert reset mid-PRESS_DB -> all outputs at reset values, no strobe.
6. With KEYPAD_AUTOREPEAT_EN, hold key 0 (row3, col1) -> valid_out drops 1 cycle every 64 held cycles; number_signal pulses on each re-assert.
